ram_port_arbiter: RTL

- Shares the single RAM port (8-bit address, 16-bit word) between the CPU datapath (port 0) and a host/program-loader (port 1).
- Sits between the CPU address/data muxing and the RAM, and drives a stall to the decoder so PC/IR/ACC enables hold while the CPU is denied.
- Weighted round-robin with bounded host bursts, plus a host lock for atomic multi-word loads.
- The address-0xFF serial-out device is downstream and sees the arbitrated write transparently.

---
 rtl/ram_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between the CPU (port 0) and a host loader (port 1).
// Latency: grants same cycle, read data one cycle later. Backpressure: a denied CPU sees cpu_stall.
// Optional macro LOCK_TIMEOUT_EN bounds host lock duration and raises a sticky lock_err.
module ram_port_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int HOST_BURST_MAX = 4,
  parameter int LOCK_TIMEOUT   = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              lock_err
);

  localparam logic [1:0] PRI_CPU   = 2'd0;
  localparam logic [1:0] PRI_HOST  = 2'd1;
  localparam logic [1:0] HOST_LOCK = 2'd2;

  localparam int BW = (HOST_BURST_MAX < 2) ? 1 : $clog2(HOST_BURST_MAX);
  localparam logic [BW-1:0] BURST_LAST = BW'(HOST_BURST_MAX - 1);

  logic [1:0]        state, state_nxt;
  logic [BW-1:0]     burst_cnt, burst_nxt;
  logic              lock_enter, lock_expired, lock_allowed;
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;

  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    case (state)
      PRI_HOST: begin
        host_gnt = host_req;
        cpu_gnt  = cpu_req & ~host_req;
      end
      HOST_LOCK: host_gnt = host_req;
      default: begin
        cpu_gnt  = cpu_req;
        host_gnt = host_req & ~cpu_req;
      end
    endcase
  end

  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign ram_addr   = host_gnt ? host_addr  : cpu_addr;
  assign ram_wdata  = host_gnt ? host_wdata : cpu_wdata;
  assign ram_we     = (cpu_gnt & cpu_we) | (host_gnt & host_we);
  assign lock_enter = host_gnt & host_lock & lock_allowed;

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    case (state)
      HOST_LOCK: begin
        if (!host_lock || lock_expired) begin
          state_nxt = PRI_CPU;
          burst_nxt = '0;
        end
      end
      PRI_HOST: begin
        if (lock_enter) begin
          state_nxt = HOST_LOCK;
        end else if (host_gnt) begin
          if (burst_cnt == BURST_LAST) begin
            state_nxt = PRI_CPU;
            burst_nxt = '0;
          end else begin
            burst_nxt = burst_cnt + BW'(1);
          end
        end else if (cpu_gnt) begin
          state_nxt = PRI_CPU;
        end
      end
      default: begin
        if (lock_enter) begin
          state_nxt = HOST_LOCK;
        end else if (cpu_gnt && host_req) begin
          state_nxt = PRI_HOST;
          burst_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= PRI_CPU;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

`ifdef LOCK_TIMEOUT_EN
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  logic [LW-1:0] lock_cnt;
  logic          relock_block;
  logic          lock_err_q;

  // After a forced release the host must drop host_lock before it can lock again.
  assign lock_expired = (state == HOST_LOCK) && host_lock && (lock_cnt == LW'(LOCK_TIMEOUT - 1));
  assign lock_allowed = ~relock_block;
  assign lock_err     = lock_err_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      lock_cnt     <= '0;
      relock_block <= 1'b0;
      lock_err_q   <= 1'b0;
    end else begin
      lock_cnt <= (state == HOST_LOCK) ? lock_cnt + LW'(1) : '0;
      if (lock_expired) begin
        relock_block <= 1'b1;
        lock_err_q   <= 1'b1;
      end else if (!host_lock) begin
        relock_block <= 1'b0;
      end
    end
  end
`else
  assign lock_expired = 1'b0;
  assign lock_allowed = 1'b1;
  assign lock_err     = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cpu_rvalid   <= 1'b0;
      host_rvalid  <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      cpu_rvalid  <= cpu_gnt & ~cpu_we;
      host_rvalid <= host_gnt & ~host_we;
      if (cpu_rvalid)  cpu_rdata_q  <= ram_rdata;
      if (host_rvalid) host_rdata_q <= ram_rdata;
    end
  end

  // RAM data arrives in the rvalid cycle; pass it through then hold it.
  assign cpu_rdata  = cpu_rvalid  ? ram_rdata : cpu_rdata_q;
  assign host_rdata = host_rvalid ? ram_rdata : host_rdata_q;

endmodule
